// File: rtl/axis_value_ramp.sv
// Slews an output value toward AXI4-Stream targets in cfg_step increments every cfg_period clocks.
// Define AXIS_VALUE_RAMP_BACKPRESSURE_EN to stall steps under backpressure instead of coalescing them.
module axis_value_ramp #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_step,
  input  logic [CNTR_WIDTH-1:0]       cfg_period,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        sts_busy
);

  localparam int unsigned DW = AXIS_TDATA_WIDTH;
  localparam int unsigned EW = AXIS_TDATA_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t                state_q;
  logic [DW-1:0]         value_q;
  logic [DW-1:0]         target_q;
  logic [CNTR_WIDTH-1:0] counter_q;

  logic [CNTR_WIDTH-1:0] p_last;
  logic [EW-1:0]         diff;
  logic [EW-1:0]         diff_abs;
  logic                  snap;
  logic [DW-1:0]         step_value;
  logic                  accept;
  logic                  out_hs;
  logic                  step_due;
  logic                  step_fire;

  // Sign-extended difference keeps full-scale swings from overflowing.
  always_comb begin
    p_last     = (cfg_period == '0) ? '0 : cfg_period - CNTR_WIDTH'(1);
    diff       = {target_q[DW-1], target_q} - {value_q[DW-1], value_q};
    diff_abs   = diff[DW] ? EW'(-diff) : diff;
    snap       = (cfg_step == '0) || (diff_abs <= {1'b0, cfg_step});
    step_value = target_q;
    if (!snap) begin
      step_value = diff[DW] ? (value_q - cfg_step) : (value_q + cfg_step);
    end
    accept    = s_axis_tready && s_axis_tvalid;
    out_hs    = m_axis_tvalid && m_axis_tready;
    step_due  = (state_q == RAMP) && (counter_q >= p_last);
`ifdef AXIS_VALUE_RAMP_BACKPRESSURE_EN
    step_fire = step_due && (!m_axis_tvalid || m_axis_tready);
`else
    step_fire = step_due;
`endif
  end

  // A new target takes priority over a step due on the same edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      value_q       <= '0;
      target_q      <= '0;
      counter_q     <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
      sts_busy      <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      if (out_hs) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        target_q  <= s_axis_tdata;
        counter_q <= '0;
        if (s_axis_tdata != value_q) begin
          state_q  <= RAMP;
          sts_busy <= 1'b1;
        end else begin
          state_q  <= IDLE;
          sts_busy <= 1'b0;
        end
      end else if (step_fire) begin
        value_q       <= step_value;
        m_axis_tvalid <= 1'b1;
        counter_q     <= '0;
        if (snap) begin
          state_q  <= IDLE;
          sts_busy <= 1'b0;
        end
      end else if (state_q == RAMP) begin
        // A blocked step holds the counter at its terminal count.
        counter_q <= step_due ? p_last : counter_q + CNTR_WIDTH'(1);
      end
    end
  end

  assign m_axis_tdata = value_q;

endmodule

// File: tb/tb_axis_value_ramp.sv
// Self-checking bench for axis_value_ramp: cycle vector tables plus an output-word scoreboard.
module tb_axis_value_ramp;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] cfg_step;
  logic [CW-1:0] cfg_period;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          sts_busy;

  axis_value_ramp #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH      (CW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_step     (cfg_step),
    .cfg_period   (cfg_period),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .sts_busy     (sts_busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          valid;
    logic          busy;
  } vec_t;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_exp;
  vec_t          vecs[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every delivered word must match the next expected word.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got 0x%08h expected no word", m_axis_tdata);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_word", m_axis_tdata, sb_exp);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_target(input logic [DW-1:0] t);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = t;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((sts_busy || m_axis_tvalid) && n < 200) begin
      tick();
      n++;
    end
    check(name, DW'(n >= 200), '0);
  endtask

  task automatic jump_to(input logic [DW-1:0] v);
    cfg_step = '0;
    exp_q.push_back(v);
    send_target(v);
    wait_quiet("jump_timeout");
  endtask

  task automatic run_vecs(input string name);
    int c = 0;
    foreach (vecs[i]) begin
      while (c < vecs[i].cyc) begin
        tick();
        c++;
      end
      check($sformatf("%s_c%0d_data", name, vecs[i].cyc), m_axis_tdata, vecs[i].data);
      check($sformatf("%s_c%0d_valid", name, vecs[i].cyc), DW'(m_axis_tvalid), DW'(vecs[i].valid));
      check($sformatf("%s_c%0d_busy", name, vecs[i].cyc), DW'(sts_busy), DW'(vecs[i].busy));
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    cfg_step      = '0;
    cfg_period    = '0;

    // Reset state and release
    repeat (3) tick();
    check("rst_s_tready", DW'(s_axis_tready), '0);
    check("rst_m_tvalid", DW'(m_axis_tvalid), '0);
    check("rst_m_tdata", m_axis_tdata, '0);
    check("rst_busy", DW'(sts_busy), '0);
    aresetn = 1'b1;
    check("rel_s_tready_pre", DW'(s_axis_tready), '0);
    tick();
    check("rel_s_tready_post", DW'(s_axis_tready), 32'd1);

    // Ramp 0 -> 35, step 10 every 4 clocks
    cfg_step   = 32'd10;
    cfg_period = 32'd4;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd35);
    vecs.push_back('{0,  32'd0,  1'b0, 1'b1});
    vecs.push_back('{3,  32'd0,  1'b0, 1'b1});
    vecs.push_back('{4,  32'd10, 1'b1, 1'b1});
    vecs.push_back('{5,  32'd10, 1'b0, 1'b1});
    vecs.push_back('{8,  32'd20, 1'b1, 1'b1});
    vecs.push_back('{12, 32'd30, 1'b1, 1'b1});
    vecs.push_back('{15, 32'd30, 1'b0, 1'b1});
    vecs.push_back('{16, 32'd35, 1'b1, 1'b0});
    vecs.push_back('{17, 32'd35, 1'b0, 1'b0});
    send_target(32'd35);
    run_vecs("ramp35");
    wait_quiet("ramp35_timeout");

    // Full-scale swing from max positive to min negative
    cfg_period = 32'd1;
    jump_to(32'h7FFF_FFFF);
    cfg_step = 32'h7FFF_FFFF;
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h8000_0001);
    exp_q.push_back(32'h8000_0000);
    send_target(32'h8000_0000);
    wait_quiet("fullscale_timeout");
    check("fullscale_final", m_axis_tdata, 32'h8000_0000);

    // Mid-ramp retarget at value 30 toward -20
    jump_to(32'd0);
    cfg_step   = 32'd5;
    cfg_period = 32'd2;
    for (int v = 5; v <= 30; v += 5) exp_q.push_back(DW'(v));
    for (int v = 25; v >= -20; v -= 5) exp_q.push_back(DW'(v));
    send_target(32'd100);
    begin
      int n = 0;
      while (m_axis_tdata != 32'd30 && n < 100) begin
        tick();
        n++;
      end
      check("retarget_reach30_timeout", DW'(n >= 100), '0);
    end
    send_target(32'hFFFF_FFEC);
    check("retarget_e0_data", m_axis_tdata, 32'd30);
    check("retarget_e0_valid", DW'(m_axis_tvalid), '0);
    tick();
    check("retarget_e1_data", m_axis_tdata, 32'd30);
    tick();
    check("retarget_e2_data", m_axis_tdata, 32'd25);
    check("retarget_e2_valid", DW'(m_axis_tvalid), 32'd1);
    wait_quiet("retarget_timeout");
    check("retarget_final", m_axis_tdata, 32'hFFFF_FFEC);

    // Downstream stalled for 5 clocks during a fast ramp to 8
    jump_to(32'd0);
    cfg_step      = 32'd1;
    cfg_period    = 32'd1;
    m_axis_tready = 1'b0;
`ifdef AXIS_VALUE_RAMP_BACKPRESSURE_EN
    for (int v = 1; v <= 8; v++) exp_q.push_back(DW'(v));
`else
    for (int v = 5; v <= 8; v++) exp_q.push_back(DW'(v));
`endif
    send_target(32'd8);
    repeat (5) tick();
    m_axis_tready = 1'b1;
    wait_quiet("stall_timeout");
    check("stall_final", m_axis_tdata, 32'd8);

    // Target equal to current value, then period 0 behaves as 1
    jump_to(32'd0);
    cfg_step = 32'd3;
    vecs.push_back('{0, 32'd0, 1'b0, 1'b0});
    vecs.push_back('{1, 32'd0, 1'b0, 1'b0});
    vecs.push_back('{3, 32'd0, 1'b0, 1'b0});
    send_target(32'd0);
    run_vecs("equal");
    cfg_period = '0;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd9);
    vecs.push_back('{0, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1, 32'd3, 1'b1, 1'b1});
    vecs.push_back('{2, 32'd6, 1'b1, 1'b1});
    vecs.push_back('{3, 32'd9, 1'b1, 1'b0});
    vecs.push_back('{4, 32'd9, 1'b0, 1'b0});
    send_target(32'd9);
    run_vecs("period0");

    // Reset mid-ramp with an undelivered word pending
    cfg_step      = 32'd1;
    cfg_period    = 32'd2;
    m_axis_tready = 1'b0;
    send_target(32'd100);
    repeat (4) tick();
    check("midrst_pending", DW'(m_axis_tvalid), 32'd1);
    aresetn = 1'b0;
    tick();
    check("midrst_tvalid", DW'(m_axis_tvalid), '0);
    check("midrst_tdata", m_axis_tdata, '0);
    check("midrst_busy", DW'(sts_busy), '0);
    check("midrst_s_tready", DW'(s_axis_tready), '0);
    m_axis_tready = 1'b1;
    aresetn = 1'b1;
    tick();
    check("midrst_rel_s_tready", DW'(s_axis_tready), 32'd1);
    repeat (3) tick();
    check("midrst_idle_tvalid", DW'(m_axis_tvalid), '0);

    check("sb_leftover", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
